// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between the
// instruction fetch side and the load/store side. Address phases are
// arbitrated (fixed data priority or round-robin). A requester that has been
// presented to the bus but not yet granted stays locked as owner. An in-order
// FIFO of owner IDs steers each response back to the side that issued it.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit DATA_PRIORITY   = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Owner encoding shared by the lock register, RR pointer and FIFO.
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic             owner_q;     // side held while LOCKED
    logic             rr_q;        // side that wins the next simultaneous request
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             owner_fifo [MAX_OUTSTANDING];
    logic             perr_q;

    logic             arb_side;
    logic             owner;
    logic             full;
    logic             accept;
    logic             pop;
    logic             head_owner;

    // Pick the winner among the live requests (only used while IDLE).
    always_comb begin
        arb_side = SIDE_I;
        if (instr_req_i && data_req_i) begin
            arb_side = DATA_PRIORITY ? SIDE_D : rr_q;
        end else if (data_req_i) begin
            arb_side = SIDE_D;
        end
    end

    // Bus request, current owner and handshake qualifiers.
    always_comb begin
        owner      = (state == LOCKED) ? owner_q : arb_side;
        full       = (count == CNT_MAX);
        // During reset all request-side outputs are forced low.
        mem_req_o  = rstn & ~full & ((state == LOCKED) | instr_req_i | data_req_i);
        accept     = mem_req_o & mem_gnt_i;
        pop        = mem_rvalid_i & (count != '0);
        head_owner = owner_fifo[rd_ptr];
    end

    // Address-phase mux: instruction side is always a full-word read.
    always_comb begin
        if (owner == SIDE_D) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = '0;
        end
    end

    // Zero-latency grant return and in-order response routing.
    always_comb begin
        instr_gnt_o    = accept & (owner == SIDE_I);
        data_gnt_o     = accept & (owner == SIDE_D);
        instr_rvalid_o = pop & (head_owner == SIDE_I);
        data_rvalid_o  = pop & (head_owner == SIDE_D);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        instr_err_o    = mem_err_i;
        data_err_o     = mem_err_i;
        busy_o         = (count != '0) | (state == LOCKED);
        protocol_err_o = perr_q;
    end

    // Lock FSM plus round-robin pointer; pointer moves only on a real grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            owner_q <= SIDE_I;
            rr_q    <= SIDE_I;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state   <= LOCKED;
                        owner_q <= owner;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                rr_q <= ~owner;
            end
        end
    end

    // Outstanding counter and FIFO pointers; simultaneous push/pop cancel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Owner-ID storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_fifo[wr_ptr] <= owner;
        end
    end

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perr_q <= 1'b0;
        end else if (mem_rvalid_i && (count == '0)) begin
            perr_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a fixed-priority instance (depth 2)
// driven from a vector table, and a round-robin instance (depth 4) checked
// with a hand-written sequence; both share the stimulus.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rstn;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    logic        ig_p, irv_p, ierr_p, dg_p, drv_p, derr_p;
    logic [31:0] ird_p, drd_p;
    logic        mreq_p, mwe_p, busy_p, perr_p;
    logic [3:0]  mbe_p;
    logic [31:0] maddr_p, mwd_p;

    logic        ig_r, irv_r, ierr_r, dg_r, drv_r, derr_r;
    logic [31:0] ird_r, drd_r;
    logic        mreq_r, mwe_r, busy_r, perr_r;
    logic [3:0]  mbe_r;
    logic [31:0] maddr_r, mwd_r;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b1)) dut_p (
        .clk(clk), .rstn(rstn),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(ig_p),
        .instr_rvalid_o(irv_p), .instr_rdata_o(ird_p), .instr_err_o(ierr_p),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(dg_p),
        .data_rvalid_o(drv_p), .data_rdata_o(drd_p), .data_err_o(derr_p),
        .mem_req_o(mreq_p), .mem_we_o(mwe_p), .mem_be_o(mbe_p), .mem_addr_o(maddr_p),
        .mem_wdata_o(mwd_p), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .busy_o(busy_p), .protocol_err_o(perr_p)
    );

    mem_port_arbiter #(.MAX_OUTSTANDING(4), .DATA_PRIORITY(1'b0)) dut_r (
        .clk(clk), .rstn(rstn),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(ig_r),
        .instr_rvalid_o(irv_r), .instr_rdata_o(ird_r), .instr_err_o(ierr_r),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(dg_r),
        .data_rvalid_o(drv_r), .data_rdata_o(drd_r), .data_err_o(derr_r),
        .mem_req_o(mreq_r), .mem_we_o(mwe_r), .mem_be_o(mbe_r), .mem_addr_o(maddr_r),
        .mem_wdata_o(mwd_r), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .busy_o(busy_r), .protocol_err_o(perr_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_ig;
        logic        e_dg;
        logic        e_irv;
        logic        e_drv;
        logic        e_mreq;
        logic        e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_busy;
        logic        e_perr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                       input logic [31:0] dwd, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err,
                       input logic e_ig, input logic e_dg, input logic e_irv,
                       input logic e_drv, input logic e_mreq, input logic e_mwe,
                       input logic [3:0] e_mbe, input logic [31:0] e_maddr,
                       input logic [31:0] e_mwd, input logic e_busy, input logic e_perr);
        vec_t v;
        v.ireq = ireq;   v.iaddr = iaddr; v.dreq = dreq;   v.dwe = dwe;
        v.dbe = dbe;     v.daddr = daddr; v.dwd = dwd;     v.gnt = gnt;
        v.rv = rv;       v.rdata = rdata; v.err = err;
        v.e_ig = e_ig;   v.e_dg = e_dg;   v.e_irv = e_irv; v.e_drv = e_drv;
        v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_mbe = e_mbe; v.e_maddr = e_maddr;
        v.e_mwd = e_mwd; v.e_busy = e_busy; v.e_perr = e_perr;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'hF; data_addr = '0; data_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        // ireq iaddr dreq we be daddr wdata gnt rv rdata err | ig dg irv drv mreq mwe mbe maddr mwd busy perr
        // Fetch read, response next cycle
        add(1, 32'h80,  0, 0, 4'hF, 32'h0,   32'h0,  1, 0, 32'h0,  0,  1, 0, 0, 0, 1, 0, 4'hF, 32'h80,  32'h0,  0, 0);
        add(0, 32'h0,   0, 0, 4'hF, 32'h0,   32'h0,  0, 1, 32'h13, 0,  0, 0, 1, 0, 0, 0, 4'hF, 32'h0,   32'h0,  1, 0);
        // Data priority on a simultaneous request, then instr, responses D then I
        add(1, 32'h84,  1, 1, 4'h3, 32'h100, 32'hAB, 1, 0, 32'h0,  0,  0, 1, 0, 0, 1, 1, 4'h3, 32'h100, 32'hAB, 0, 0);
        add(1, 32'h84,  0, 0, 4'hF, 32'h0,   32'h0,  1, 1, 32'h11, 0,  1, 0, 0, 1, 1, 0, 4'hF, 32'h84,  32'h0,  1, 0);
        add(0, 32'h0,   0, 0, 4'hF, 32'h0,   32'h0,  0, 1, 32'h22, 1,  0, 0, 1, 0, 0, 0, 4'hF, 32'h0,   32'h0,  1, 0);
        // Lock on instr 0x200 for three cycles while data requests
        add(1, 32'h200, 0, 0, 4'hF, 32'h300, 32'h0,  0, 0, 32'h0,  0,  0, 0, 0, 0, 1, 0, 4'hF, 32'h200, 32'h0,  0, 0);
        add(1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0,  0, 0, 32'h0,  0,  0, 0, 0, 0, 1, 0, 4'hF, 32'h200, 32'h0,  1, 0);
        add(1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0,  0, 0, 32'h0,  0,  0, 0, 0, 0, 1, 0, 4'hF, 32'h200, 32'h0,  1, 0);
        add(1, 32'h200, 1, 0, 4'hF, 32'h300, 32'h0,  1, 0, 32'h0,  0,  1, 0, 0, 0, 1, 0, 4'hF, 32'h200, 32'h0,  1, 0);
        add(0, 32'h0,   1, 0, 4'hF, 32'h300, 32'h0,  1, 0, 32'h0,  0,  0, 1, 0, 0, 1, 0, 4'hF, 32'h300, 32'h0,  1, 0);
        // Full at 2 outstanding: no request, even with a same-cycle rvalid
        add(1, 32'h400, 1, 0, 4'hF, 32'h300, 32'h0,  1, 0, 32'h0,  0,  0, 0, 0, 0, 0, 0, 4'hF, 32'h300, 32'h0,  1, 0);
        add(1, 32'h400, 1, 0, 4'hF, 32'h300, 32'h0,  1, 1, 32'h33, 0,  0, 0, 1, 0, 0, 0, 4'hF, 32'h300, 32'h0,  1, 0);
        add(1, 32'h400, 1, 0, 4'hF, 32'h300, 32'h0,  1, 0, 32'h0,  0,  0, 1, 0, 0, 1, 0, 4'hF, 32'h300, 32'h0,  1, 0);
        add(0, 32'h0,   0, 0, 4'hF, 32'h0,   32'h0,  0, 1, 32'h44, 0,  0, 0, 0, 1, 0, 0, 4'hF, 32'h0,   32'h0,  1, 0);
        add(0, 32'h0,   0, 0, 4'hF, 32'h0,   32'h0,  0, 1, 32'h55, 0,  0, 0, 0, 1, 0, 0, 4'hF, 32'h0,   32'h0,  1, 0);
        // Spurious rvalid sets the sticky error
        add(0, 32'h0,   0, 0, 4'hF, 32'h0,   32'h0,  0, 1, 32'h66, 0,  0, 0, 0, 0, 0, 0, 4'hF, 32'h0,   32'h0,  0, 0);
        add(0, 32'h0,   0, 0, 4'hF, 32'h0,   32'h0,  0, 0, 32'h0,  0,  0, 0, 0, 0, 0, 0, 4'hF, 32'h0,   32'h0,  0, 1);
        add(0, 32'h0,   0, 0, 4'hF, 32'h0,   32'h0,  0, 0, 32'h0,  0,  0, 0, 0, 0, 0, 0, 4'hF, 32'h0,   32'h0,  0, 1);

        // Reset state, with requests active so the masking is visible
        idle_inputs();
        rstn = 1'b0;
        instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
        @(negedge clk);
        #1;
        chk("rst mem_req_p", mreq_p, 0);
        chk("rst mem_req_r", mreq_r, 0);
        chk("rst instr_gnt", ig_p, 0);
        chk("rst data_gnt", dg_p, 0);
        chk("rst busy", busy_p, 0);
        chk("rst perr", perr_p, 0);
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        @(negedge clk);

        // Table pass on the fixed-priority instance
        for (int i = 0; i < vecs.size(); i++) begin
            instr_req = vecs[i].ireq;  instr_addr = vecs[i].iaddr;
            data_req = vecs[i].dreq;   data_we = vecs[i].dwe;    data_be = vecs[i].dbe;
            data_addr = vecs[i].daddr; data_wdata = vecs[i].dwd;
            mem_gnt = vecs[i].gnt;     mem_rvalid = vecs[i].rv;
            mem_rdata = vecs[i].rdata; mem_err = vecs[i].err;
            #1;
            chk($sformatf("v%0d instr_gnt", i), ig_p, vecs[i].e_ig);
            chk($sformatf("v%0d data_gnt", i), dg_p, vecs[i].e_dg);
            chk($sformatf("v%0d instr_rvalid", i), irv_p, vecs[i].e_irv);
            chk($sformatf("v%0d data_rvalid", i), drv_p, vecs[i].e_drv);
            chk($sformatf("v%0d mem_req", i), mreq_p, vecs[i].e_mreq);
            chk($sformatf("v%0d mem_we", i), mwe_p, vecs[i].e_mwe);
            chk($sformatf("v%0d mem_be", i), mbe_p, vecs[i].e_mbe);
            chk($sformatf("v%0d mem_addr", i), maddr_p, vecs[i].e_maddr);
            chk($sformatf("v%0d busy", i), busy_p, vecs[i].e_busy);
            chk($sformatf("v%0d perr", i), perr_p, vecs[i].e_perr);
            if (vecs[i].e_mwe) chk($sformatf("v%0d mem_wdata", i), mwd_p, vecs[i].e_mwd);
            if (vecs[i].rv) begin
                chk($sformatf("v%0d instr_rdata", i), ird_p, vecs[i].rdata);
                chk($sformatf("v%0d data_rdata", i), drd_p, vecs[i].rdata);
                chk($sformatf("v%0d instr_err", i), ierr_p, vecs[i].err);
                chk($sformatf("v%0d data_err", i), derr_p, vecs[i].err);
            end
            @(negedge clk);
        end

        // Round-robin: both sides request for four cycles, grants I,D,I,D
        do_reset();
        instr_req = 1'b1; instr_addr = 32'h600;
        data_req = 1'b1; data_addr = 32'h700; data_be = 4'hF;
        mem_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d instr_gnt", k), ig_r, (k % 2 == 0));
            chk($sformatf("rr%0d data_gnt", k), dg_r, (k % 2 == 1));
            chk($sformatf("rr%0d mem_addr", k), maddr_r, (k % 2 == 0) ? 32'h600 : 32'h700);
            @(negedge clk);
        end
        idle_inputs();
        mem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 32'hA0 + k;
            #1;
            chk($sformatf("rr%0d instr_rvalid", k), irv_r, (k % 2 == 0));
            chk($sformatf("rr%0d data_rvalid", k), drv_r, (k % 2 == 1));
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        #1;
        chk("rr drained busy", busy_r, 0);
        chk("rr no perr", perr_r, 0);
        @(negedge clk);

        // Reset with one transaction outstanding, then a late response
        do_reset();
        instr_req = 1'b1; instr_addr = 32'h500; mem_gnt = 1'b1;
        #1;
        chk("mid instr_gnt", ig_p, 1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mid busy before reset", busy_p, 1);
        @(negedge clk);
        instr_req = 1'b1;
        rstn = 1'b0;
        #1;
        chk("mid busy in reset", busy_p, 0);
        chk("mid mem_req in reset", mreq_p, 0);
        @(negedge clk);
        instr_req = 1'b0;
        rstn = 1'b1;
        mem_rvalid = 1'b1;
        #1;
        chk("late instr_rvalid", irv_p, 0);
        chk("late data_rvalid", drv_p, 0);
        chk("late perr not yet", perr_p, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("late perr set", perr_p, 1);
        chk("late busy", busy_p, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory bus port between the fetch stage (instruction side) and the load/store unit (data side). Both sides use the req/gnt/rvalid protocol. The block arbitrates address phases, holds the winner until the memory grants, and tracks outstanding transactions in order. Each response (rvalid/rdata/err) is routed back to the requester that issued it. It sits between the core and the memory interconnect.

Parameters:
MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (1..4); depth of the owner-ID FIFO.
DATA_PRIORITY, 1, 1 = data side has fixed priority over instruction side; 0 = round-robin.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_addr_i  in  32  fetch address
instr_gnt_o  out  1  fetch address phase accepted
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch response data
instr_err_o  out  1  fetch response error (valid with rvalid)
data_req_i  in  1  load/store request
data_we_i  in  1  1 = store
data_be_i  in  4  byte enables
data_addr_i  in  32  load/store address
data_wdata_i  in  32  store data
data_gnt_o  out  1  load/store address phase accepted
data_rvalid_o  out  1  load/store response valid
data_rdata_o  out  32  load data
data_err_o  out  1  load/store error
mem_req_o  out  1  bus request
mem_we_o  out  1  bus write enable
mem_be_o  out  4  bus byte enables
mem_addr_o  out  32  bus address
mem_wdata_o  out  32  bus write data
mem_gnt_i  in  1  bus grant
mem_rvalid_i  in  1  bus response valid
mem_rdata_i  in  32  bus response data
mem_err_i  in  1  bus response error
busy_o  out  1  1 when any transaction is outstanding or locked
protocol_err_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- Reset is asynchronous on rstn low, in any state, including mid-transaction. Reset state: FSM IDLE, outstanding count 0, FIFO empty, RR pointer = instruction side, protocol_err_o 0. All request-side outputs read 0 during reset. Outstanding transactions are discarded; a late rvalid after reset sets protocol_err_o.
- FSM has two states:
  - IDLE: no locked owner. The winner is chosen combinationally from the current requests. mem_req_o = (instr_req_i | data_req_i) & ~full.
  - LOCKED: mem_req_o was asserted without mem_gnt_i. The owner is held and mem_* address-phase signals are driven from the owner's inputs. The other requester is ignored until grant.
  - IDLE -> LOCKED when mem_req_o=1 and mem_gnt_i=0.
  - LOCKED -> IDLE on mem_gnt_i=1.
- Arbitration in IDLE:
  - DATA_PRIORITY=1: data wins whenever data_req_i=1.
  - DATA_PRIORITY=0: on a simultaneous request, the side not granted last wins. The RR pointer updates only on a completed grant.
  - A single requester always wins.
- Grant path is zero-latency combinational: <side>_gnt_o = mem_gnt_i & mem_req_o & (owner == side). The loser's gnt_o is 0.
- Instruction requests drive mem_we_o=0 and mem_be_o=4'hF. mem_wdata_o is don't-care for instruction requests.
- Outstanding tracking:
  - A FIFO of 1-bit owner IDs and a counter of width clog2(MAX_OUTSTANDING+1).
  - Push on each accepted grant; pop on mem_rvalid_i.
  - Push and pop in the same cycle leave the count unchanged.
  - full = (count == MAX_OUTSTANDING). When full, mem_req_o=0 and no gnt_o is issued, even if rvalid arrives that same cycle.
  - FIFO wrap-around uses modulo-MAX_OUTSTANDING pointers.
- Response routing (combinational, in order):
  - <side>_rvalid_o = mem_rvalid_i & (count != 0) & (head owner == side).
  - rdata and err are passed to both sides; only rvalid is gated.
  - Response may arrive in the cycle after grant at the earliest. Same-cycle rvalid for the grant being pushed is a protocol violation.
- Spurious rvalid: mem_rvalid_i with count == 0 is dropped, both rvalid_o stay 0, and protocol_err_o is set until reset.
- busy_o = (count != 0) | (state == LOCKED).
- A requester deasserting req while LOCKED is a requester protocol violation; the arbiter keeps driving the latched owner's current inputs.

Test Plan:
1. Fetch read: instr_req_i=1, instr_addr_i=0x80, mem_gnt_i=1 same cycle; next cycle mem_rvalid_i=1, rdata=0x00000013 -> instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with rdata 0x13 in cycle 1; data_rvalid_o stays 0.
2. Priority (DATA_PRIORITY=1): both req in the same cycle, data store addr 0x100, be=4'b0011, wdata=0xAB; mem_gnt_i=1 every cycle -> cycle 0 mem_we_o=1, mem_be_o=3, data_gnt_o=1; cycle 1 instr granted; responses route data then instr.
3. Round-robin (DATA_PRIORITY=0): both req held for 4 cycles with gnt every cycle -> grant order I, D, I, D; responses return in that order, each to the correct side.
4. Lock: instr req addr 0x200 with mem_gnt_i=0 for 3 cycles; data_req_i rises in cycle 1 -> mem_addr_o stays 0x200 and data_gnt_o=0 throughout; cycle 3 gnt -> instr_gnt_o=1; data granted in cycle 4.
5. Full: MAX_OUTSTANDING=2, two grants with no rvalid -> mem_req_o=0 next cycle despite req; rvalid arrives -> count drops to 1 and mem_req_o re-asserts the following cycle.
6. Errors/reset: rvalid with count 0 -> protocol_err_o=1 and sticky. Separately, rstn low with 1 outstanding -> busy_o=0 and count 0; subsequent rvalid -> protocol_err_o=1.
